operand_fetch: RTL

Issue-side client of the 16×32 register file and CPSR flag store. Accepts one decoded instruction at a time, reads its source registers and flags, and presents the operands to the execute stage. Also drives the file's write and flag-write ports from the writeback bus. A 17-bit scoreboard (16 GPRs plus flags) stalls reads until pending writes have landed.

---
 rtl/operand_fetch.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Issue-side client of a 16x32 register file plus CPSR flag store.
//            Accepts one decoded instruction at a time. It reads the source
//            registers and flags, holds them for the execute stage, and drives
//            the register file write port from the writeback bus. A 17-bit
//            scoreboard (16 GPRs + flags) stalls reads while writes are pending.
// Macro    : OPERAND_FETCH_FORWARD_EN - when defined, a pending source that
//            the current writeback targets does not stall. Its operand is
//            taken from the writeback bus.
// Ports    : clk, rst_n (sync, active-low)
//            in_*   : instruction handshake and decoded fields
//            out_*  : registered operand handshake and pass-through fields
//            wb_*   : writeback bus (register data + optional flags)
//            rmEn/rnEn/cpsr_rdEn, rdAddrm/rdAddrn, rdDatam/rdDatan/cpsrData :
//                     register file read port (file reads on negedge)
//            write/wrAddr/wrData/s/wr_to_cpsr : register file write port
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rm,
  input  logic [3:0]  in_rn,
  input  logic        in_useRm,
  input  logic        in_useRn,
  input  logic        in_useFlags,
  input  logic [3:0]  in_rd,
  input  logic        in_hasRd,
  input  logic        in_setFlags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_opm,
  output logic [31:0] out_opn,
  output logic [3:0]  out_flags,
  output logic [3:0]  out_rd,
  output logic        out_hasRd,
  output logic        out_setFlags,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        wb_setFlags,
  input  logic [3:0]  wb_flags,
  output logic        rmEn,
  output logic        rnEn,
  output logic        cpsr_rdEn,
  output logic [3:0]  rdAddrm,
  output logic [3:0]  rdAddrn,
  input  logic [31:0] rdDatam,
  input  logic [31:0] rdDatan,
  input  logic [3:0]  cpsrData,
  output logic        write,
  output logic [3:0]  wrAddr,
  output logic [31:0] wrData,
  output logic        s,
  output logic [3:0]  wr_to_cpsr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  rm_q, rn_q, rd_q;
  logic        use_rm_q, use_rn_q, use_flags_q, has_rd_q, set_flags_q;

  logic [15:0] gpr_busy, gpr_busy_next;
  logic        flag_busy, flag_busy_next;

  logic        wb_flag;
  logic        pend_m, pend_n, pend_f;
  logic        fwd_m, fwd_n, fwd_f;
  logic        stall, go;

  assign wb_flag = wb_valid & wb_setFlags;

  // Pending checks use the scoreboard as it stands before this
  // instruction's own reservation, so a source equal to rd is not self-blocking.
  assign pend_m = use_rm_q    & gpr_busy[rm_q];
  assign pend_n = use_rn_q    & gpr_busy[rn_q];
  assign pend_f = use_flags_q & flag_busy;

`ifdef OPERAND_FETCH_FORWARD_EN
  // The file reads on the negedge before the posedge write lands, so a
  // matching writeback must be bypassed rather than read back.
  assign fwd_m = pend_m & wb_valid & (wb_addr == rm_q);
  assign fwd_n = pend_n & wb_valid & (wb_addr == rn_q);
  assign fwd_f = pend_f & wb_flag;
`else
  assign fwd_m = 1'b0;
  assign fwd_n = 1'b0;
  assign fwd_f = 1'b0;
`endif

  assign stall = (pend_m & ~fwd_m) | (pend_n & ~fwd_n) | (pend_f & ~fwd_f);
  assign go    = (state == ISSUE) & ~stall;

  assign in_ready  = (state == IDLE);
  assign rmEn      = rst_n & go & use_rm_q;
  assign rnEn      = rst_n & go & use_rn_q;
  assign cpsr_rdEn = rst_n & go & use_flags_q;
  assign rdAddrm   = rm_q;
  assign rdAddrn   = rn_q;

  assign write      = rst_n & wb_valid;
  assign wrAddr     = wb_addr;
  assign wrData     = wb_data;
  assign s          = rst_n & wb_flag;
  assign wr_to_cpsr = wb_flags;

  // Clear first, then reserve: a same-cycle reserve belongs to the younger
  // instruction and must win.
  always_comb begin
    gpr_busy_next  = gpr_busy;
    flag_busy_next = flag_busy;
    if (wb_valid) gpr_busy_next[wb_addr] = 1'b0;
    if (wb_flag)  flag_busy_next = 1'b0;
    if (go) begin
      if (has_rd_q)    gpr_busy_next[rd_q] = 1'b1;
      if (set_flags_q) flag_busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      gpr_busy     <= 16'd0;
      flag_busy    <= 1'b0;
      rm_q         <= 4'd0;
      rn_q         <= 4'd0;
      rd_q         <= 4'd0;
      use_rm_q     <= 1'b0;
      use_rn_q     <= 1'b0;
      use_flags_q  <= 1'b0;
      has_rd_q     <= 1'b0;
      set_flags_q  <= 1'b0;
      out_valid    <= 1'b0;
      out_opm      <= 32'd0;
      out_opn      <= 32'd0;
      out_flags    <= 4'd0;
      out_rd       <= 4'd0;
      out_hasRd    <= 1'b0;
      out_setFlags <= 1'b0;
    end else begin
      gpr_busy  <= gpr_busy_next;
      flag_busy <= flag_busy_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            rm_q        <= in_rm;
            rn_q        <= in_rn;
            rd_q        <= in_rd;
            use_rm_q    <= in_useRm;
            use_rn_q    <= in_useRn;
            use_flags_q <= in_useFlags;
            has_rd_q    <= in_hasRd;
            set_flags_q <= in_setFlags;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            out_opm      <= use_rm_q    ? (fwd_m ? wb_data  : rdDatam)  : 32'd0;
            out_opn      <= use_rn_q    ? (fwd_n ? wb_data  : rdDatan)  : 32'd0;
            out_flags    <= use_flags_q ? (fwd_f ? wb_flags : cpsrData) : 4'd0;
            out_rd       <= rd_q;
            out_hasRd    <= has_rd_q;
            out_setFlags <= set_flags_q;
            out_valid    <= 1'b1;
            state        <= VALID;
          end
        end
        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
